// File: rtl/pc_redirect.sv
// Fetch PC register and redirect/flush control for the RV32I pipeline.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic        TRAP_FLUSH_M = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        misalign_exc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;

    logic [0:0]  state;
    logic        br_tk;
    logic        br_aligned;
    logic        br_redir;
    logic        redirect;
    logic [31:0] pc_next;

    assign br_tk      = br_valid & br_taken;
    assign br_aligned = (br_target[1:0] == 2'b00);
    // A misaligned target never redirects; the CSR unit follows up with a trap.
    assign br_redir   = br_tk & br_aligned;
    assign redirect   = trap_req | mret_req | br_redir;

    assign pc_plus4_f   = pc_f + 32'd4;
    assign misalign_exc = br_tk & ~br_aligned;
    assign flush_d      = redirect | (state == REDIR);
    assign flush_e      = redirect;
    assign flush_m      = trap_req & TRAP_FLUSH_M;

    always_comb begin
        pc_next = pc_plus4_f;
        if (trap_req)
            pc_next = trap_vector;
        else if (mret_req)
            pc_next = mepc;
        else if (br_redir)
            pc_next = br_target;
        else if (stall_if)
            pc_next = pc_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f  <= RESET_PC;
            state <= RUN;
        end else begin
            pc_f  <= pc_next;
            state <= redirect ? REDIR : RUN;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_taken_q;

    // Counting ignores stall_if; a branch squashed by a trap is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= 32'd0;
            stat_taken_q    <= 32'd0;
        end else if (br_valid && !trap_req) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (br_taken && br_aligned)
                stat_taken_q <= stat_taken_q + 32'd1;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`else
    assign stat_branches = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Directed-vector bench for pc_redirect (RESET_PC = 32'h1000, TRAP_FLUSH_M = 1).
module tb_pc_redirect;

    logic        clk;
    logic        rst_n;
    logic        stall_if;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic        mret_req;
    logic [31:0] mepc;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        flush_d;
    logic        flush_e;
    logic        flush_m;
    logic        misalign_exc;
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;

    int checks = 0;
    int errors = 0;

    pc_redirect #(.RESET_PC(32'h0000_1000), .TRAP_FLUSH_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .trap_req(trap_req), .trap_vector(trap_vector),
        .mret_req(mret_req), .mepc(mepc),
        .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .misalign_exc(misalign_exc),
        .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, ready to drive new inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_if = 0; br_valid = 0; br_taken = 0; trap_req = 0; mret_req = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        br_target = 0; trap_vector = 0; mepc = 0;
        rst_n = 0;
        #12;
        checks++; if (pc_f !== 32'h1000) begin errors++; $display("FAIL rst_pc: got %h want %h", pc_f, 32'h1000); end
        checks++; if ({flush_d, flush_e, flush_m, misalign_exc} !== 4'b0000) begin errors++; $display("FAIL rst_flush: got %b want 0000", {flush_d, flush_e, flush_m, misalign_exc}); end
        checks++; if ({stat_branches, stat_taken} !== 64'd0) begin errors++; $display("FAIL rst_stats: got %h/%h want 0/0", stat_branches, stat_taken); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (pc_f !== 32'h1000) begin errors++; $display("FAIL rel_pc0: got %h want %h", pc_f, 32'h1000); end
        next_cycle();
        checks++; if (pc_f !== 32'h1004) begin errors++; $display("FAIL rel_pc1: got %h want %h", pc_f, 32'h1004); end
        next_cycle();
        checks++; if (pc_f !== 32'h1008) begin errors++; $display("FAIL rel_pc2: got %h want %h", pc_f, 32'h1008); end
        checks++; if (pc_plus4_f !== 32'h100C) begin errors++; $display("FAIL rel_plus4: got %h want %h", pc_plus4_f, 32'h100C); end
        checks++; if ({flush_d, flush_e, flush_m} !== 3'b000) begin errors++; $display("FAIL rel_flush: got %b want 000", {flush_d, flush_e, flush_m}); end
    endtask

    task automatic test_branch();
        br_valid = 1; br_taken = 1; br_target = 32'h2000;
        #1;
        checks++; if ({flush_d, flush_e, flush_m, misalign_exc} !== 4'b1100) begin errors++; $display("FAIL br_flush: got %b want 1100", {flush_d, flush_e, flush_m, misalign_exc}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (pc_f !== 32'h2000) begin errors++; $display("FAIL br_pc: got %h want %h", pc_f, 32'h2000); end
        checks++; if ({flush_d, flush_e} !== 2'b10) begin errors++; $display("FAIL br_redir_flush: got %b want 10", {flush_d, flush_e}); end
        next_cycle();
        #1;
        checks++; if (pc_f !== 32'h2004) begin errors++; $display("FAIL br_seq_pc: got %h want %h", pc_f, 32'h2004); end
        checks++; if ({flush_d, flush_e, flush_m} !== 3'b000) begin errors++; $display("FAIL br_run_flush: got %b want 000", {flush_d, flush_e, flush_m}); end
    endtask

    task automatic test_misalign_trap();
        br_valid = 1; br_taken = 1; br_target = 32'h2002;
        #1;
        checks++; if ({flush_d, flush_e, misalign_exc} !== 3'b001) begin errors++; $display("FAIL mis_out: got %b want 001", {flush_d, flush_e, misalign_exc}); end
        next_cycle();
        clear_inputs();
        trap_req = 1; trap_vector = 32'h0100;
        #1;
        checks++; if (pc_f !== 32'h2008) begin errors++; $display("FAIL mis_pc: got %h want %h", pc_f, 32'h2008); end
        checks++; if ({flush_d, flush_e, flush_m, misalign_exc} !== 4'b1110) begin errors++; $display("FAIL trap_flush: got %b want 1110", {flush_d, flush_e, flush_m, misalign_exc}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (pc_f !== 32'h0100) begin errors++; $display("FAIL trap_pc: got %h want %h", pc_f, 32'h0100); end
        checks++; if ({flush_d, flush_m} !== 2'b10) begin errors++; $display("FAIL trap_redir: got %b want 10", {flush_d, flush_m}); end
    endtask

    task automatic test_stall();
        stall_if = 1;
        #1;
        checks++; if (pc_f !== 32'h0104) begin errors++; $display("FAIL stall_pc0: got %h want %h", pc_f, 32'h0104); end
        next_cycle();
        br_valid = 1; br_taken = 1; br_target = 32'h3000;
        #1;
        checks++; if (pc_f !== 32'h0104) begin errors++; $display("FAIL stall_hold: got %h want %h", pc_f, 32'h0104); end
        checks++; if (flush_e !== 1'b1) begin errors++; $display("FAIL stall_br_flush: got %b want 1", flush_e); end
        next_cycle();
        br_valid = 0; br_taken = 0;
        #1;
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL stall_br_pc: got %h want %h", pc_f, 32'h3000); end
        checks++; if (flush_d !== 1'b1) begin errors++; $display("FAIL stall_redir: got %b want 1", flush_d); end
        next_cycle();
        stall_if = 0;
        #1;
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL stall_hold2: got %h want %h", pc_f, 32'h3000); end
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL stall_run: got %b want 0", flush_d); end
    endtask

    task automatic test_trap_mret();
        next_cycle();
        trap_req = 1; mret_req = 1; trap_vector = 32'h0100; mepc = 32'h4444;
        #1;
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL tm_pc0: got %h want %h", pc_f, 32'h3004); end
        checks++; if (flush_m !== 1'b1) begin errors++; $display("FAIL tm_flush_m: got %b want 1", flush_m); end
        next_cycle();
        trap_req = 0;
        #1;
        checks++; if (pc_f !== 32'h0100) begin errors++; $display("FAIL tm_pc: got %h want %h", pc_f, 32'h0100); end
        checks++; if ({flush_d, flush_e, flush_m} !== 3'b110) begin errors++; $display("FAIL mret_flush: got %b want 110", {flush_d, flush_e, flush_m}); end
        next_cycle();
        mret_req = 0;
        #1;
        checks++; if (pc_f !== 32'h4444) begin errors++; $display("FAIL mret_pc: got %h want %h", pc_f, 32'h4444); end
    endtask

    task automatic test_wrap();
        next_cycle();
        br_valid = 1; br_taken = 1; br_target = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_f !== 32'h4448) begin errors++; $display("FAIL wrap_pc0: got %h want %h", pc_f, 32'h4448); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (pc_plus4_f !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want %h", pc_plus4_f, 32'h0); end
        next_cycle();
        #1;
        checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc_f, 32'h0); end
    endtask

    task automatic test_reset_mid_redirect();
        br_valid = 1; br_taken = 1; br_target = 32'h5000;
        next_cycle();
        clear_inputs();
        rst_n = 0;
        #1;
        checks++; if (pc_f !== 32'h1000) begin errors++; $display("FAIL mid_rst_pc: got %h want %h", pc_f, 32'h1000); end
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL mid_rst_flush: got %b want 0", flush_d); end
        @(negedge clk);
        rst_n = 1;
        next_cycle();
        checks++; if (pc_f !== 32'h1004) begin errors++; $display("FAIL mid_rst_seq: got %h want %h", pc_f, 32'h1004); end
    endtask

    task automatic test_stats();
        logic [6:0]  bv;
        logic [6:0]  bt;
        logic [6:0]  tr;
        logic [31:0] tg [7];
        logic [31:0] exp_b;
        logic [31:0] exp_t;
        bv = 7'b1110111; bt = 7'b1111101; tr = 7'b0100000;
        tg = '{32'h6000, 32'h6100, 32'h6002, 32'h7000, 32'h7000, 32'h8000, 32'h9000};
        for (int i = 0; i < 7; i++) begin
            br_valid = bv[i]; br_taken = bt[i]; br_target = tg[i]; trap_req = tr[i];
            #1;
            if (i == 3) begin
                checks++; if (flush_e !== 1'b0) begin errors++; $display("FAIL st_ignore_taken: got %b want 0", flush_e); end
            end
            next_cycle();
        end
        clear_inputs();
`ifdef BRANCH_STATS_EN
        exp_b = 32'd5; exp_t = 32'd3;
`else
        exp_b = 32'd0; exp_t = 32'd0;
`endif
        #1;
        checks++; if (pc_f !== 32'h9000) begin errors++; $display("FAIL st_pc: got %h want %h", pc_f, 32'h9000); end
        checks++; if (stat_branches !== exp_b) begin errors++; $display("FAIL st_branches: got %0d want %0d", stat_branches, exp_b); end
        checks++; if (stat_taken !== exp_t) begin errors++; $display("FAIL st_taken: got %0d want %0d", stat_taken, exp_t); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_misalign_trap();
        next_cycle();
        test_stall();
        test_trap_mret();
        test_wrap();
        test_reset_mid_redirect();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
